mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Consumer of the EX stage outputs: performs the MEM stage of the pipeline.
//  Drives loads and stores onto a req/ack data-memory bus, extracts and extends
//  load data, stalls the pipeline while an access is outstanding, resolves
//  branches, and registers the write-back bundle for the WB stage.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in ACCESS without dmem_ack before abort (>=2)
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   EX/MEM bundle valid this cycle
//  flush          in   1   kill the current bundle (squash)
//  in_RegWrite    in   1   write-back enable
//  in_MemWrite    in   1   store
//  in_MemRead     in   1   load
//  in_MemToReg    in   1   WB selects load data
//  in_load_mode   in   2   00 word, 01 half signed, 10 byte signed, 11 byte unsigned (stores: 00 w, 01 h, 1x b)
//  in_writebackDestination in 5  destination register
//  in_aluResult   in   32  effective address / ALU result
//  in_rt          in   32  store data
//  in_pc          in   32  branch target from EX
//  in_branch      in   1   branch instruction
//  in_zero        in   1   ALU zero flag
//  dmem_req       out  1   memory request
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_be        out  4   byte enables, lane i = bits 8i+7:8i (little-endian)
//  dmem_ack       in   1   request completed; rdata valid same cycle
//  dmem_rdata     in   32  read data
//  stall          out  1   hold IF/ID/EX and the EX/MEM register
//  pc_src         out  1   take branch
//  branch_target  out  32  = in_pc
//  wb_valid       out  1   WB bundle valid
//  wb_RegWrite    out  1   WB write enable
//  wb_MemToReg    out  1   WB mux select
//  wb_dest        out  5   WB register
//  wb_alu_result  out  32  registered ALU result
//  wb_read_data   out  32  extended load data
//  mem_err        out  1   sticky: misaligned access or timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter 0; mem_err 0.
//  mem_op = in_valid & !flush & (in_MemRead|in_MemWrite). MemRead wins if both are set.
//  Misaligned: half with addr[0]=1; word with addr[1:0]!=0. No bus request, mem_err<=1,
//   wb_valid<=1 with wb_RegWrite=0 next cycle, no stall.
//  FSM IDLE: aligned mem_op -> capture bundle, stall=1 (combinational), ->ACCESS.
//   Non-mem valid bundle -> registered to wb_* next cycle, wb_read_data=0, no stall.
//   No valid bundle -> wb_valid<=0.
//  ACCESS: dmem_req=1; addr/we/wdata/be held constant until ack; stall=1.
//   On dmem_ack -> IDLE; next cycle wb_valid=1, load data extracted at addr[1:0]
//   and sign/zero-extended per in_load_mode, stall=0. Minimum load latency:
//   capture T0, ack T1, wb_valid T2.
//  Store lanes: byte be=1<<a[1:0], wdata={4{rt[7:0]}}; half be=a[1]?1100:0011,
//   wdata={2{rt[15:0]}}; word be=1111.
//  Timeout: counter increments each ACCESS cycle; MEM_TIMEOUT cycles without ack ->
//   drop req, mem_err<=1, ->IDLE, wb_valid<=1 with wb_RegWrite=0.
//  flush in IDLE: bundle discarded (wb_valid<=0, no request).
//  flush in ACCESS: request is not aborted; completes on ack, but wb_RegWrite forced 0.
//  dmem_ack outside ACCESS is ignored. mem_err clears only on reset.
//  pc_src = in_valid & !flush & in_branch & in_zero & !stall (combinational).
//  rst_n low mid-ACCESS: req drops immediately (async), FSM->IDLE.
// TESTING
//  lw addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> req 3 cycles, wb_read_data 0xDEADBEEF, stall 4 cycles
//  lb addr 0x103, rdata 0x80112233 -> wb_read_data 0xFFFFFF80; mode 11 -> 0x00000080
//  sh addr 0x0A, rt 0x1234ABCD -> dmem_be 1100, wdata 0xABCDABCD, dmem_addr 0x08
//  lw addr 0x102 -> no dmem_req, mem_err=1, wb_RegWrite=0
//  no ack for MEM_TIMEOUT=16 cycles -> req drops at cycle 16, mem_err=1, stall falls
//  beq, in_zero=1, in_pc 0x40 -> pc_src=1, branch_target 0x40; with flush -> pc_src=0

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues loads/stores on a req/ack data bus, stalls while
// an access is outstanding, extends load data and registers the WB bundle.
module mem_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        flush,
  input  logic        in_RegWrite,
  input  logic        in_MemWrite,
  input  logic        in_MemRead,
  input  logic        in_MemToReg,
  input  logic [1:0]  in_load_mode,
  input  logic [4:0]  in_writebackDestination,
  input  logic [31:0] in_aluResult,
  input  logic [31:0] in_rt,
  input  logic [31:0] in_pc,
  input  logic        in_branch,
  input  logic        in_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic        wb_MemToReg,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic        mem_err
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          rd_r, rd_s, kill_r, kill_s;
  logic          regwrite_r, regwrite_s, memtoreg_r, memtoreg_s;
  logic [1:0]    mode_r, mode_s, lane_r, lane_s;
  logic [4:0]    dest_r, dest_s;
  logic [31:0]   alu_r, alu_s;
  logic          req_s, we_s;
  logic [31:0]   addr_s, wdata_s;
  logic [3:0]    be_s;
  logic          wb_valid_s, wb_regwrite_s, wb_memtoreg_s, err_s;
  logic [4:0]    wb_dest_s;
  logic [31:0]   wb_alu_s, wb_rdata_s;
  logic          mem_op_s, misalign_s;

  // Store mode 1x is a byte, so the access size decodes the same way for loads and stores.
  function automatic logic [3:0] store_be(input logic [1:0] mode, input logic [1:0] a);
    logic [3:0] be;
    case (mode)
      2'b00:   be = 4'b1111;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b0001 << a;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] mode, input logic [31:0] rt);
    logic [31:0] w;
    case (mode)
      2'b00:   w = rt;
      2'b01:   w = {2{rt[15:0]}};
      default: w = {4{rt[7:0]}};
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] mode, input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(rdata >> {a, 3'b000});
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (mode)
      2'b00:   r = rdata;
      2'b01:   r = {{16{h[15]}}, h};
      2'b10:   r = {{24{b[7]}}, b};
      default: r = {24'h000000, b};
    endcase
    return r;
  endfunction

  assign mem_op_s   = in_valid & ~flush & (in_MemRead | in_MemWrite);
  assign misalign_s = ((in_load_mode == 2'b00) & (in_aluResult[1:0] != 2'b00)) |
                      ((in_load_mode == 2'b01) & in_aluResult[0]);
  assign stall         = (state_r == ACCESS) | ((state_r == IDLE) & mem_op_s & ~misalign_s);
  assign pc_src        = in_valid & ~flush & in_branch & in_zero & ~stall;
  assign branch_target = in_pc;

  // Next-state and next-register values for the FSM, bus and WB bundle.
  always_comb begin
    state_s = state_r;   cnt_s = cnt_r;
    rd_s = rd_r;         kill_s = kill_r;
    regwrite_s = regwrite_r; memtoreg_s = memtoreg_r;
    mode_s = mode_r;     lane_s = lane_r;
    dest_s = dest_r;     alu_s = alu_r;
    req_s = dmem_req;    we_s = dmem_we;
    addr_s = dmem_addr;  wdata_s = dmem_wdata; be_s = dmem_be;
    wb_valid_s = 1'b0;   wb_regwrite_s = wb_RegWrite; wb_memtoreg_s = wb_MemToReg;
    wb_dest_s = wb_dest; wb_alu_s = wb_alu_result;    wb_rdata_s = wb_read_data;
    err_s = mem_err;
    case (state_r)
      IDLE: begin
        if (mem_op_s && !misalign_s) begin
          state_s    = ACCESS;
          cnt_s      = '0;
          rd_s       = in_MemRead;
          kill_s     = 1'b0;
          regwrite_s = in_RegWrite;
          memtoreg_s = in_MemToReg;
          mode_s     = in_load_mode;
          lane_s     = in_aluResult[1:0];
          dest_s     = in_writebackDestination;
          alu_s      = in_aluResult;
          req_s      = 1'b1;
          we_s       = ~in_MemRead;
          addr_s     = {in_aluResult[31:2], 2'b00};
          be_s       = in_MemRead ? 4'b1111 : store_be(in_load_mode, in_aluResult[1:0]);
          wdata_s    = in_MemRead ? 32'h0000_0000 : store_wdata(in_load_mode, in_rt);
        end else if (mem_op_s) begin
          err_s         = 1'b1;
          wb_valid_s    = 1'b1;
          wb_regwrite_s = 1'b0;
          wb_memtoreg_s = in_MemToReg;
          wb_dest_s     = in_writebackDestination;
          wb_alu_s      = in_aluResult;
          wb_rdata_s    = 32'h0000_0000;
        end else if (in_valid && !flush) begin
          wb_valid_s    = 1'b1;
          wb_regwrite_s = in_RegWrite;
          wb_memtoreg_s = in_MemToReg;
          wb_dest_s     = in_writebackDestination;
          wb_alu_s      = in_aluResult;
          wb_rdata_s    = 32'h0000_0000;
        end else begin
          wb_valid_s = 1'b0;
        end
      end
      ACCESS: begin
        kill_s = kill_r | flush;
        if (dmem_ack) begin
          state_s       = IDLE;
          req_s         = 1'b0;
          we_s          = 1'b0;
          wb_valid_s    = 1'b1;
          wb_regwrite_s = regwrite_r & ~kill_r & ~flush;
          wb_memtoreg_s = memtoreg_r;
          wb_dest_s     = dest_r;
          wb_alu_s      = alu_r;
          wb_rdata_s    = rd_r ? load_extract(mode_r, lane_r, dmem_rdata) : 32'h0000_0000;
        end else if (cnt_r == CNT_LAST) begin
          // Abort: the slave never answered, so the bundle retires without a write.
          state_s       = IDLE;
          req_s         = 1'b0;
          we_s          = 1'b0;
          err_s         = 1'b1;
          wb_valid_s    = 1'b1;
          wb_regwrite_s = 1'b0;
          wb_memtoreg_s = memtoreg_r;
          wb_dest_s     = dest_r;
          wb_alu_s      = alu_r;
          wb_rdata_s    = 32'h0000_0000;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
        we_s    = 1'b0;
      end
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;   cnt_r <= '0;
      rd_r <= 1'b0;      kill_r <= 1'b0;
      regwrite_r <= 1'b0; memtoreg_r <= 1'b0;
      mode_r <= 2'b00;   lane_r <= 2'b00;
      dest_r <= 5'd0;    alu_r <= 32'h0000_0000;
      dmem_req <= 1'b0;  dmem_we <= 1'b0;
      dmem_addr <= 32'h0000_0000; dmem_wdata <= 32'h0000_0000; dmem_be <= 4'b0000;
      wb_valid <= 1'b0;  wb_RegWrite <= 1'b0; wb_MemToReg <= 1'b0;
      wb_dest <= 5'd0;   wb_alu_result <= 32'h0000_0000; wb_read_data <= 32'h0000_0000;
      mem_err <= 1'b0;
    end else begin
      state_r <= state_s;  cnt_r <= cnt_s;
      rd_r <= rd_s;        kill_r <= kill_s;
      regwrite_r <= regwrite_s; memtoreg_r <= memtoreg_s;
      mode_r <= mode_s;    lane_r <= lane_s;
      dest_r <= dest_s;    alu_r <= alu_s;
      dmem_req <= req_s;   dmem_we <= we_s;
      dmem_addr <= addr_s; dmem_wdata <= wdata_s; dmem_be <= be_s;
      wb_valid <= wb_valid_s; wb_RegWrite <= wb_regwrite_s; wb_MemToReg <= wb_memtoreg_s;
      wb_dest <= wb_dest_s; wb_alu_result <= wb_alu_s; wb_read_data <= wb_rdata_s;
      mem_err <= err_s;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed and randomized MEM-stage traffic
// compared against a byte-level behavioural model of loads, stores and the WB bundle.
module tb_mem_stage_ctrl;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg;
  logic [1:0]  in_load_mode;
  logic [4:0]  in_writebackDestination;
  logic [31:0] in_aluResult, in_rt, in_pc;
  logic        in_branch, in_zero;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall, pc_src;
  logic [31:0] branch_target;
  logic        wb_valid, wb_RegWrite, wb_MemToReg;
  logic [4:0]  wb_dest;
  logic [31:0] wb_alu_result, wb_read_data;
  logic        mem_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  bit exp_err  = 1'b0;

  mem_stage_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
    .in_RegWrite(in_RegWrite), .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead),
    .in_MemToReg(in_MemToReg), .in_load_mode(in_load_mode),
    .in_writebackDestination(in_writebackDestination), .in_aluResult(in_aluResult),
    .in_rt(in_rt), .in_pc(in_pc), .in_branch(in_branch), .in_zero(in_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .pc_src(pc_src), .branch_target(branch_target), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_dest(wb_dest),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Access size in bytes: mode 00 word, 01 half, otherwise byte.
  function automatic int size_of(input logic [1:0] mode);
    return (mode == 2'd0) ? 4 : (mode == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] mode, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int unsigned a, b, h;
    longint v;
    a = addr % 4;
    b = (rdata >> (8 * a)) % 256;
    h = (rdata >> (8 * (a - a % 2))) % 65536;
    case (mode)
      2'd0:    v = longint'(rdata);
      2'd1:    v = (h >= 32768) ? longint'(h) - 65536 : longint'(h);
      2'd2:    v = (b >= 128) ? longint'(b) - 256 : longint'(b);
      default: v = longint'(b);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] mode, input logic [31:0] addr);
    int sz, base;
    logic [3:0] be;
    sz = size_of(mode);
    base = ((addr % 4) / sz) * sz;
    for (int k = 0; k < 4; k++) be[k] = (k >= base) && (k < base + sz);
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] mode, input logic [31:0] rt);
    int sz;
    logic [31:0] w;
    sz = size_of(mode);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rt[8*(k % sz) +: 8];
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; in_RegWrite = 1'b0; in_MemWrite = 1'b0; in_MemRead = 1'b0;
    in_MemToReg = 1'b0; in_load_mode = 2'd0; in_writebackDestination = 5'd0;
    in_aluResult = 32'h0; in_rt = 32'h0; in_pc = 32'h0; in_branch = 1'b0; in_zero = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  // One load or store from capture to write-back, with ack after `delay` request cycles.
  task automatic run_access(input bit rd, input logic [1:0] mode, input logic [31:0] addr,
                            input logic [31:0] rt, input logic [31:0] rdata, input int delay,
                            input bit rw, input int flush_at, input bit no_ack, input string nm);
    bit mis, acked, at_neg, killed;
    int reqs, stalls, exp_reqs;
    logic [4:0] d;
    mis = (addr % size_of(mode)) != 0;
    d = 5'($urandom);
    in_valid = 1'b1; in_MemRead = rd; in_MemWrite = !rd; in_RegWrite = rw; in_MemToReg = rd;
    in_load_mode = mode; in_writebackDestination = d; in_aluResult = addr; in_rt = rt;
    in_branch = 1'b1; in_zero = 1'b1; in_pc = $urandom; flush = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (stall !== !mis) begin miss_cnt++; $display("FAIL %s capture stall: got %b want %b", nm, stall, !mis); end
    vec_cnt++;
    if (pc_src !== mis) begin miss_cnt++; $display("FAIL %s pc_src under stall: got %b want %b", nm, pc_src, mis); end
    vec_cnt++;
    if (dmem_req !== 1'b0) begin miss_cnt++; $display("FAIL %s early req: got %b want 0", nm, dmem_req); end
    step();
    in_valid = 1'b0; in_branch = 1'b0; in_zero = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0;
    if (mis) begin
      exp_err = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (dmem_req !== 1'b0) begin miss_cnt++; $display("FAIL %s misaligned req: got %b want 0", nm, dmem_req); end
      vec_cnt++;
      if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0) begin
        miss_cnt++; $display("FAIL %s misaligned wb valid/regwrite: got %b%b want 10", nm, wb_valid, wb_RegWrite);
      end
      vec_cnt++;
      if (mem_err !== 1'b1 || stall !== 1'b0) begin
        miss_cnt++; $display("FAIL %s misaligned err/stall: got %b%b want 10", nm, mem_err, stall);
      end
      step();
      return;
    end
    stalls = stall_seen_at_capture(!mis);
    reqs = 0; acked = 1'b0; at_neg = 1'b0; killed = 1'b0;
    dmem_rdata = rdata;
    for (int k = 1; k <= 40; k++) begin
      flush = (k == flush_at);
      if (k == flush_at) killed = 1'b1;
      dmem_ack = !no_ack && (k == delay);
      @(negedge clk);
      if (!dmem_req) begin at_neg = 1'b1; break; end
      reqs++;
      if (stall) stalls++;
      vec_cnt++;
      if (dmem_addr !== {addr[31:2], 2'b00} || dmem_we !== !rd) begin
        miss_cnt++; $display("FAIL %s bus addr/we: got %h/%b want %h/%b", nm, dmem_addr, dmem_we, {addr[31:2], 2'b00}, !rd);
      end
      if (!rd) begin
        vec_cnt++;
        if (dmem_be !== exp_be(mode, addr) || dmem_wdata !== exp_wdata(mode, rt)) begin
          miss_cnt++; $display("FAIL %s store lanes: got be %b wdata %h want be %b wdata %h", nm,
                               dmem_be, dmem_wdata, exp_be(mode, addr), exp_wdata(mode, rt));
        end
      end
      step();
      if (dmem_ack) begin acked = 1'b1; break; end
    end
    dmem_ack = 1'b0; flush = 1'b0;
    if (!at_neg) @(negedge clk);
    exp_reqs = no_ack ? int'(TMO) : delay;
    if (no_ack) exp_err = 1'b1;
    vec_cnt++;
    if (reqs !== exp_reqs || stalls !== exp_reqs + 1) begin
      miss_cnt++; $display("FAIL %s req/stall cycles: got %0d/%0d want %0d/%0d", nm, reqs, stalls, exp_reqs, exp_reqs + 1);
    end
    vec_cnt++;
    if (wb_valid !== 1'b1 || stall !== 1'b0 || dmem_req !== 1'b0) begin
      miss_cnt++; $display("FAIL %s retire valid/stall/req: got %b%b%b want 100", nm, wb_valid, stall, dmem_req);
    end
    vec_cnt++;
    if (wb_RegWrite !== (rw && !no_ack && !killed)) begin
      miss_cnt++; $display("FAIL %s wb_RegWrite: got %b want %b", nm, wb_RegWrite, rw && !no_ack && !killed);
    end
    vec_cnt++;
    if (wb_read_data !== ((rd && !no_ack) ? exp_load(mode, addr, rdata) : 32'h0)) begin
      miss_cnt++; $display("FAIL %s wb_read_data: got %h want %h", nm, wb_read_data,
                           (rd && !no_ack) ? exp_load(mode, addr, rdata) : 32'h0);
    end
    vec_cnt++;
    if (wb_dest !== d || wb_alu_result !== addr || wb_MemToReg !== rd || mem_err !== exp_err) begin
      miss_cnt++; $display("FAIL %s wb fields: got dest %0d alu %h m2r %b err %b want %0d %h %b %b", nm,
                           wb_dest, wb_alu_result, wb_MemToReg, mem_err, d, addr, rd, exp_err);
    end
    step();
  endtask

  function automatic int stall_seen_at_capture(input bit expected_stall);
    return expected_stall ? 1 : 0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({dmem_req, dmem_we, dmem_be, stall, pc_src, wb_valid, wb_RegWrite, wb_MemToReg, mem_err} !== 13'h0) begin
      miss_cnt++; $display("FAIL reset flags: got %b want 0", {dmem_req, dmem_we, dmem_be, stall, pc_src,
                           wb_valid, wb_RegWrite, wb_MemToReg, mem_err});
    end
    vec_cnt++;
    if ({dmem_addr, dmem_wdata, wb_alu_result, wb_read_data, branch_target} !== 160'h0 || wb_dest !== 5'd0) begin
      miss_cnt++; $display("FAIL reset data: got %h %h %h %h %h %h want 0", dmem_addr, dmem_wdata,
                           wb_alu_result, wb_read_data, branch_target, wb_dest);
    end
    step();
    rst_n = 1'b1;
    exp_err = 1'b0;
    step();
  endtask

  task automatic test_directed();
    run_access(1'b1, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b1, 0, 1'b0, "lw_0x100");
    run_access(1'b1, 2'd2, 32'h103, 32'h0, 32'h80112233, 1, 1'b1, 0, 1'b0, "lb_0x103");
    run_access(1'b1, 2'd3, 32'h103, 32'h0, 32'h80112233, 2, 1'b1, 0, 1'b0, "lbu_0x103");
    run_access(1'b0, 2'd1, 32'h0A, 32'h1234ABCD, 32'h0, 2, 1'b0, 0, 1'b0, "sh_0x0A");
  endtask

  task automatic test_random_access();
    logic [1:0]  mode;
    logic [31:0] addr;
    int sz;
    for (int i = 0; i < 24; i++) begin
      mode = 2'($urandom_range(0, 3));
      sz = size_of(mode);
      addr = $urandom;
      if ($urandom_range(0, 7) != 0) addr = addr - (addr % sz);
      run_access(1'($urandom), mode, addr, $urandom, $urandom, $urandom_range(1, 5),
                 1'($urandom), 0, 1'b0, "rand_access");
    end
  endtask

  // Back-to-back non-memory bundles, with stray acks that must be ignored.
  task automatic test_back_to_back();
    bit pv, v, f, br, z, rw, m2r;
    logic [4:0]  pd, d;
    logic [31:0] pa, a, pc;
    bit prw, pm2r;
    pv = 1'b0; prw = 1'b0; pm2r = 1'b0; pd = 5'd0; pa = 32'h0;
    for (int i = 0; i < 16; i++) begin
      v = ($urandom_range(0, 3) != 0); f = ($urandom_range(0, 4) == 0);
      br = 1'($urandom); z = 1'($urandom); rw = 1'($urandom); m2r = 1'($urandom);
      d = 5'($urandom); a = $urandom; pc = $urandom;
      in_valid = v; flush = f; in_branch = br; in_zero = z; in_RegWrite = rw; in_MemToReg = m2r;
      in_writebackDestination = d; in_aluResult = a; in_pc = pc; in_MemRead = 1'b0; in_MemWrite = 1'b0;
      dmem_ack = 1'($urandom);
      @(negedge clk);
      vec_cnt++;
      if (pc_src !== (v && !f && br && z) || branch_target !== pc || stall !== 1'b0 || dmem_req !== 1'b0) begin
        miss_cnt++; $display("FAIL b2b comb: got pc_src %b tgt %h stall %b req %b want %b %h 0 0",
                             pc_src, branch_target, stall, dmem_req, v && !f && br && z, pc);
      end
      if (i > 0) begin
        vec_cnt++;
        if (wb_valid !== pv) begin miss_cnt++; $display("FAIL b2b wb_valid: got %b want %b", wb_valid, pv); end
        if (pv) begin
          vec_cnt++;
          if (wb_RegWrite !== prw || wb_MemToReg !== pm2r || wb_dest !== pd || wb_alu_result !== pa || wb_read_data !== 32'h0) begin
            miss_cnt++; $display("FAIL b2b wb bundle: got %b %b %0d %h %h want %b %b %0d %h 0",
                                 wb_RegWrite, wb_MemToReg, wb_dest, wb_alu_result, wb_read_data, prw, pm2r, pd, pa);
          end
        end
      end
      pv = v && !f; prw = rw; pm2r = m2r; pd = d; pa = a;
      step();
    end
    idle_inputs();
    run_access(1'b1, 2'd1, 32'h200, 32'h0, 32'h8001_7FFF, 1, 1'b1, 0, 1'b0, "b2b_lh");
  endtask

  task automatic test_branch();
    in_valid = 1'b1; in_branch = 1'b1; in_zero = 1'b1; in_pc = 32'h40;
    @(negedge clk);
    vec_cnt++;
    if (pc_src !== 1'b1 || branch_target !== 32'h40) begin
      miss_cnt++; $display("FAIL beq taken: got %b %h want 1 00000040", pc_src, branch_target);
    end
    flush = 1'b1;
    #1;
    vec_cnt++;
    if (pc_src !== 1'b0) begin miss_cnt++; $display("FAIL beq flushed: got %b want 0", pc_src); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; flush = 1'b1; in_MemRead = 1'b1; in_RegWrite = 1'b1; in_aluResult = 32'h300;
    @(negedge clk);
    vec_cnt++;
    if (stall !== 1'b0) begin miss_cnt++; $display("FAIL flush_idle stall: got %b want 0", stall); end
    step();
    idle_inputs();
    @(negedge clk);
    vec_cnt++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL flush_idle req/wb_valid: got %b%b want 00", dmem_req, wb_valid);
    end
    step();
    run_access(1'b1, 2'd0, 32'h400, 32'h0, 32'hCAFEF00D, 3, 1'b1, 2, 1'b0, "flush_access");
  endtask

  task automatic test_errors();
    run_access(1'b1, 2'd0, 32'h102, 32'h0, 32'h0, 1, 1'b1, 0, 1'b0, "lw_misaligned");
    run_access(1'b1, 2'd0, 32'h500, 32'h0, 32'h0, 1, 1'b1, 0, 1'b1, "timeout");
    run_access(1'b0, 2'd3, 32'h501, 32'h55, 32'h0, 2, 1'b0, 0, 1'b0, "sb_after_err");
  endtask

  task automatic test_reset_mid_access();
    in_valid = 1'b1; in_MemRead = 1'b1; in_aluResult = 32'h600;
    step();
    idle_inputs();
    @(negedge clk);
    vec_cnt++;
    if (dmem_req !== 1'b1) begin miss_cnt++; $display("FAIL rst_mid pre req: got %b want 1", dmem_req); end
    #1 rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    vec_cnt++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0) begin
      miss_cnt++; $display("FAIL rst_mid async: got req %b stall %b err %b want 000", dmem_req, stall, mem_err);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      miss_cnt++; $display("FAIL rst_mid idle: got req %b stall %b want 00", dmem_req, stall);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_access();
    test_back_to_back();
    test_branch();
    test_flush();
    test_errors();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
